// File: rtl/singleriscv_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcodes, funct
// fields, ALU operation and writeback encodings, plus the ALU itself as a
// pure function so the datapath in the top stays readable.
package singleriscv_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;

    // funct3 for OP / OP_IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for memory and JALR
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 variants
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    // Base (funct7 = 0) ALU operation selected by funct3
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    // 32-bit ALU; shifts use only b[4:0], arithmetic wraps modulo 2^32
    function automatic logic [31:0] alu_compute(input alu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLL:   res = a << b[4:0];
            ALU_SLT:   res = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU:  res = {31'd0, (a < b)};
            ALU_XOR:   res = a ^ b;
            ALU_SRL:   res = a >> b[4:0];
            ALU_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_PASSB: res = b;
            default:   res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/singleriscv_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// x0 always reads as zero and writes addressed to it are dropped.
module singleriscv_regfile
    import singleriscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];

    // Next register state: apply the single write unless it targets x0
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 5'd0)) begin
            regs_d[waddr_i] = wdata_i;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; x0 is hard-wired to zero
    always_comb begin
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'd0;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'd0;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/singleriscv.sv
// Single-cycle RV32I core (integer subset with LW/SW only). Every
// instruction decodes, executes and commits in one clock; unsupported
// encodings fall through as NOPs.
module singleriscv
    import singleriscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  funct7_s;

    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;

    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] src_a_s;
    logic [31:0] src_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] wb_data_s;

    alu_op_e     alu_op_s;
    wb_sel_e     wb_sel_s;
    logic        rd_we_s;
    logic        store_s;
    logic        branch_s;
    logic        take_s;
    logic        jal_s;
    logic        jalr_s;

    // Field extraction and sign-extended immediates for every format
    always_comb begin
        opcode_s = instr[6:0];
        rd_s     = instr[11:7];
        funct3_s = instr[14:12];
        rs1_s    = instr[19:15];
        rs2_s    = instr[24:20];
        funct7_s = instr[31:25];
        imm_i_s  = {{20{instr[31]}}, instr[31:20]};
        imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u_s  = {instr[31:12], 12'd0};
        imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    // Main decoder; anything not explicitly recognised keeps the NOP defaults
    always_comb begin
        alu_op_s = ALU_ADD;
        src_a_s  = rs1_val_s;
        src_b_s  = rs2_val_s;
        wb_sel_s = WB_ALU;
        rd_we_s  = 1'b0;
        store_s  = 1'b0;
        branch_s = 1'b0;
        jal_s    = 1'b0;
        jalr_s   = 1'b0;
        case (opcode_s)
            OP: begin
                if (funct7_s == F7_BASE) begin
                    rd_we_s  = 1'b1;
                    alu_op_s = alu_from_f3(funct3_s);
                end else if ((funct7_s == F7_ALT) && (funct3_s == F3_ADD_SUB)) begin
                    rd_we_s  = 1'b1;
                    alu_op_s = ALU_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == F3_SRL_SRA)) begin
                    rd_we_s  = 1'b1;
                    alu_op_s = ALU_SRA;
                end else begin
                    rd_we_s  = 1'b0;
                end
            end
            OP_IMM: begin
                src_b_s = imm_i_s;
                if (funct3_s == F3_SLL) begin
                    if (funct7_s == F7_BASE) begin
                        rd_we_s  = 1'b1;
                        alu_op_s = ALU_SLL;
                    end else begin
                        rd_we_s  = 1'b0;
                    end
                end else if (funct3_s == F3_SRL_SRA) begin
                    if (funct7_s == F7_BASE) begin
                        rd_we_s  = 1'b1;
                        alu_op_s = ALU_SRL;
                    end else if (funct7_s == F7_ALT) begin
                        rd_we_s  = 1'b1;
                        alu_op_s = ALU_SRA;
                    end else begin
                        rd_we_s  = 1'b0;
                    end
                end else begin
                    rd_we_s  = 1'b1;
                    alu_op_s = alu_from_f3(funct3_s);
                end
            end
            LOAD: begin
                src_b_s = imm_i_s;
                if (funct3_s == F3_LW) begin
                    rd_we_s  = 1'b1;
                    wb_sel_s = WB_MEM;
                end else begin
                    rd_we_s  = 1'b0;
                end
            end
            STORE: begin
                src_b_s = imm_s_s;
                if (funct3_s == F3_SW) begin
                    store_s = 1'b1;
                end else begin
                    store_s = 1'b0;
                end
            end
            BRANCH: begin
                case (funct3_s)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: branch_s = 1'b1;
                    default:                                          branch_s = 1'b0;
                endcase
            end
            JAL: begin
                rd_we_s  = 1'b1;
                wb_sel_s = WB_PC4;
                jal_s    = 1'b1;
            end
            JALR: begin
                src_b_s = imm_i_s;
                if (funct3_s == F3_JALR) begin
                    rd_we_s  = 1'b1;
                    wb_sel_s = WB_PC4;
                    jalr_s   = 1'b1;
                end else begin
                    rd_we_s  = 1'b0;
                end
            end
            LUI: begin
                src_b_s  = imm_u_s;
                alu_op_s = ALU_PASSB;
                rd_we_s  = 1'b1;
            end
            AUIPC: begin
                src_a_s = pc_q;
                src_b_s = imm_u_s;
                rd_we_s = 1'b1;
            end
            default: begin
                rd_we_s = 1'b0;
            end
        endcase
    end

    // ALU: also provides the load/store address and the JALR target
    always_comb begin
        alu_res_s = alu_compute(alu_op_s, src_a_s, src_b_s);
    end

    // Branch condition evaluation on the two register operands
    always_comb begin
        case (funct3_s)
            F3_BEQ:  take_s = (rs1_val_s == rs2_val_s);
            F3_BNE:  take_s = (rs1_val_s != rs2_val_s);
            F3_BLT:  take_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            F3_BGE:  take_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            F3_BLTU: take_s = (rs1_val_s < rs2_val_s);
            F3_BGEU: take_s = (rs1_val_s >= rs2_val_s);
            default: take_s = 1'b0;
        endcase
    end

    // Next-PC selection; no alignment checking is performed
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        if (jal_s) begin
            pc_d = pc_q + imm_j_s;
        end else if (jalr_s) begin
            pc_d = alu_res_s & 32'hFFFF_FFFE;
        end else if (branch_s && take_s) begin
            pc_d = pc_q + imm_b_s;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // Register-file writeback source
    always_comb begin
        case (wb_sel_s)
            WB_ALU:  wb_data_s = alu_res_s;
            WB_MEM:  wb_data_s = readdata;
            WB_PC4:  wb_data_s = pc_plus4_s;
            default: wb_data_s = alu_res_s;
        endcase
    end

    // Program counter with synchronous active-low reset to address 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

    singleriscv_regfile u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we_i     (rd_we_s & reset_n),
        .waddr_i  (rd_s),
        .wdata_i  (wb_data_s),
        .raddr1_i (rs1_s),
        .raddr2_i (rs2_s),
        .rdata1_o (rs1_val_s),
        .rdata2_o (rs2_val_s)
    );

    // The store strobe is combinational in the SW cycle and blocked in reset
    assign pc        = pc_q;
    assign memwrite  = store_s & reset_n;
    assign dataadr   = alu_res_s;
    assign writedata = rs2_val_s;

endmodule

// File: tb/tb_singleriscv.sv
// Self-checking bench for singleriscv. The bench plays instruction memory
// directly: each step presents one instruction word together with the
// values the core must show for it (pc, memwrite, dataadr, writedata).
module tb_singleriscv;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        mw;
        logic        ca;
        logic [31:0] adr;
        logic        cw;
        logic [31:0] wd;
    } step_t;

    step_t sb_q[$];

    singleriscv dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic step_t mk(input logic [31:0] ins, input logic [31:0] p, input logic mw,
                                 input logic ca, input logic [31:0] adr,
                                 input logic cw, input logic [31:0] wd);
        step_t s;
        s.ins = ins; s.pc = p; s.mw = mw; s.ca = ca; s.adr = adr; s.cw = cw; s.wd = wd;
        return s;
    endfunction

    // Present one instruction and record what the core must show for it
    task automatic issue(input step_t s);
        instr = s.ins;
        sb_q.push_back(s);
    endtask

    // Two reset edges, then release just after an edge so pc=0 is fetched
    task automatic do_reset();
        reset_n = 1'b0;
        instr   = NOP;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        step_t t[$];
        step_t e;
        reset_n  = 1'b0;
        readdata = 32'h0;
        instr    = enc_s(12'd8, 5'd3, 5'd0, 3'b010);
        #1;
        total++;
        if (memwrite !== 1'b0) begin
            bad++; $display("FAIL reset.mw_pre actual=%b expected=0", memwrite);
        end
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(mk(instr, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL reset.pc[%0d] actual=%h expected=%h", k, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL reset.mw[%0d] actual=%b expected=%b", k, memwrite, e.mw);
            end
        end
        reset_n = 1'b1;
        t.push_back(mk(NOP, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(NOP, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(NOP, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL reset_run[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL reset_run[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_store();
        step_t t[$];
        step_t e;
        do_reset();
        t.push_back(mk(enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0,  1'b0, 1'b1, 32'h5,        1'b0, 32'h0));
        t.push_back(mk(enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd4,  1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 32'h0));
        t.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),         32'd8,  1'b0, 1'b1, 32'h2,        1'b1, 32'hFFFFFFFD));
        t.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),         32'd12, 1'b0, 1'b1, 32'h8,        1'b1, 32'hFFFFFFFD));
        t.push_back(mk(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4),         32'd16, 1'b0, 1'b1, 32'h1,        1'b1, 32'h5));
        t.push_back(mk(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd4),         32'd20, 1'b0, 1'b1, 32'h0,        1'b1, 32'h5));
        t.push_back(mk(enc_i(12'h401, 5'd2, 3'b101, 5'd4, 7'b0010011), 32'd24, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'h01C, 5'd2, 3'b101, 5'd4, 7'b0010011), 32'd28, 1'b0, 1'b1, 32'h0000000F, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'hFFF, 5'd1, 3'b100, 5'd4, 7'b0010011), 32'd32, 1'b0, 1'b1, 32'hFFFFFFFA, 1'b0, 32'h0));
        t.push_back(mk(enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd4),         32'd36, 1'b0, 1'b1, 32'h000000A0, 1'b1, 32'h5));
        t.push_back(mk(enc_s(12'd8, 5'd3, 5'd0, 3'b010),               32'd40, 1'b1, 1'b1, 32'h8,        1'b1, 32'h2));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL alu[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL alu[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL alu[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL alu[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_signal();
        step_t t[$];
        step_t e;
        do_reset();
        t.push_back(mk(enc_u(20'h00008, 5'd5, 7'b0110111),             32'd0,  1'b0, 1'b1, 32'h00008000, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'hFFC, 5'd5, 3'b000, 5'd5, 7'b0010011), 32'd4,  1'b0, 1'b1, 32'h00007FFC, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'd1,   5'd0, 3'b000, 5'd6, 7'b0010011), 32'd8,  1'b0, 1'b1, 32'h1,        1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd6, 5'd5, 3'b010),               32'd12, 1'b1, 1'b1, 32'h00007FFC, 1'b1, 32'h1));
        t.push_back(mk(enc_u(20'h00001, 5'd7, 7'b0010111),             32'd16, 1'b0, 1'b1, 32'h00001010, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd7, 5'd0, 3'b010),               32'd20, 1'b1, 1'b1, 32'h0,        1'b1, 32'h00001010));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL done_sig[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL done_sig[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL done_sig[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL done_sig[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        step_t t[$];
        step_t e;
        do_reset();
        t.push_back(mk(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0,  1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'd1,   5'd0, 3'b000, 5'd2, 7'b0010011), 32'd4,  1'b0, 1'b1, 32'h1,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'd8,     5'd2, 5'd1, 3'b100),           32'd8,  1'b0, 1'b0, 32'h0,        1'b1, 32'h1));
        t.push_back(mk(enc_b(13'd8,     5'd2, 5'd1, 3'b110),           32'd16, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'h1FFC,  5'd0, 5'd0, 3'b000),           32'd20, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'd8,     5'd2, 5'd1, 3'b101),           32'd16, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'd12,    5'd2, 5'd1, 3'b111),           32'd20, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'd8,     5'd1, 5'd1, 3'b001),           32'd32, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(enc_b(13'h1FDC,  5'd2, 5'd1, 3'b001),           32'd36, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        t.push_back(mk(NOP,                                            32'd0,  1'b0, 1'b0, 32'h0,        1'b0, 32'h0));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL branch[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL branch[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL branch[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL branch[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        step_t t[$];
        step_t e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            t.push_back(mk(NOP, 32'(k * 4), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        end
        t.push_back(mk(enc_j(21'd16, 5'd1),                            32'h10, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd1, 5'd0, 3'b010),               32'h20, 1'b1, 1'b1, 32'h0,  1'b1, 32'h14));
        t.push_back(mk(enc_i(12'd1,   5'd1, 3'b000, 5'd0, 7'b1100111), 32'h24, 1'b0, 1'b1, 32'h15, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'hFFC, 5'd1, 3'b000, 5'd5, 7'b1100111), 32'h14, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd5, 5'd0, 3'b010),               32'h10, 1'b1, 1'b1, 32'h0,  1'b1, 32'h18));
        t.push_back(mk(NOP,                                            32'h14, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL jump[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL jump[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL jump[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL jump[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_x0();
        step_t t[$];
        step_t e;
        do_reset();
        readdata = 32'hDEADBEEF;
        t.push_back(mk(enc_i(12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011),   32'd0,  1'b0, 1'b1, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd4, 5'd7, 5'd0, 3'b010),               32'd4,  1'b1, 1'b1, 32'h4, 1'b1, 32'hDEADBEEF));
        t.push_back(mk(enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011),   32'd8,  1'b0, 1'b1, 32'h7, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd0, 5'd0, 3'b010),               32'd12, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL load_x0[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL load_x0[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL load_x0[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL load_x0[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_nop();
        step_t t[$];
        step_t e;
        do_reset();
        readdata = 32'h12345678;
        t.push_back(mk(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011),   32'd0,  1'b0, 1'b1, 32'h5, 1'b0, 32'h0));
        t.push_back(mk(32'hFFFFFFFF,                                   32'd4,  1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd8),         32'd8,  1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd1, 5'd0, 3'b000),               32'd12, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_i(12'h401, 5'd1, 3'b001, 5'd9, 7'b0010011), 32'd16, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd8, 5'd0, 3'b010),               32'd20, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0));
        t.push_back(mk(enc_s(12'd4, 5'd9, 5'd0, 3'b010),               32'd24, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0));
        t.push_back(mk(enc_i(12'd0, 5'd0, 3'b000, 5'd10, 7'b0000011),  32'd28, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(enc_s(12'd0, 5'd10, 5'd0, 3'b010),              32'd32, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0));
        t.push_back(mk(enc_b(13'd8, 5'd0, 5'd0, 3'b010),               32'd36, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        t.push_back(mk(NOP,                                            32'd40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        for (int i = 0; i < t.size(); i++) begin
            issue(t[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++; $display("FAIL nop[%0d].pc actual=%h expected=%h", i, pc, e.pc);
            end
            total++;
            if (memwrite !== e.mw) begin
                bad++; $display("FAIL nop[%0d].mw actual=%b expected=%b", i, memwrite, e.mw);
            end
            if (e.ca) begin
                total++;
                if (dataadr !== e.adr) begin
                    bad++; $display("FAIL nop[%0d].adr actual=%h expected=%h", i, dataadr, e.adr);
                end
            end
            if (e.cw) begin
                total++;
                if (writedata !== e.wd) begin
                    bad++; $display("FAIL nop[%0d].wd actual=%h expected=%h", i, writedata, e.wd);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu_store();
        test_store_signal();
        test_branch();
        test_jump();
        test_load_x0();
        test_illegal_nop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/singleriscv.md
SINGLERISCV -- requirements
Module: singleriscv

Interface
REQ-001 SHALL have a port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have a port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have a port pc, output, 32 bits: address of the current instruction; the instruction memory indexes it with pc[9:2].
REQ-004 SHALL have a port instr, input, 32 bits: instruction word at pc, combinational from the instruction memory.
REQ-005 SHALL have a port memwrite, output, 1 bit: store strobe for the data memory/IO block this cycle.
REQ-006 SHALL have a port dataadr, output, 32 bits: data address, equal to the ALU result (rs1 + imm for loads/stores).
REQ-007 SHALL have a port writedata, output, 32 bits: store data, the rs2 value.
REQ-008 SHALL have a port readdata, input, 32 bits: load data, combinational from the data memory/IO block.

Function
REQ-009 SHALL be single-cycle: each instruction completes in one clk cycle; PC and register-file writes commit on the rising edge.
REQ-010 SHALL implement RV32I base integer instructions in the following groups:
- LUI, AUIPC
- JAL, JALR
- BEQ, BNE, BLT, BGE, BLTU, BGEU
- LW, SW
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
REQ-011 SHALL execute any other opcode, or any other funct3/funct7 combination, as a NOP: pc+4, no register write, memwrite=0.
REQ-012 SHALL have a register file of 32x32: two combinational read ports and one write port; x0 reads 0 and writes to x0 are discarded.
REQ-013 SHALL sign-extend immediates per RV32I format (I/S/B/U/J); shift amounts are imm[4:0] or rs2[4:0].
REQ-014 SHALL compare signed for SLT/SLTI/BLT/BGE and unsigned for SLTU/SLTIU/BLTU/BGEU; all arithmetic is modulo 2^32 with no overflow trap.
REQ-015 SHALL select the next PC as follows; misalignment raises no exception:
- default: pc+4
- taken branch: pc+immB
- JAL: pc+immJ
- JALR: (rs1+immI) with bit0 cleared
REQ-016 SHALL write pc+4 to rd for JAL/JALR, with the link value computed from the pre-jump pc.
REQ-017 SHALL drive memwrite=1 only during SW, combinationally in that cycle; dataadr=rs1+immS and writedata=rs2.
REQ-018 SHALL write readdata to rd at the end of an LW cycle; dataadr=rs1+immI and memwrite=0.
REQ-019 SHALL keep dataadr=ALU result and writedata=rs2 for every instruction; they are don't-care when memwrite=0.

Reset
REQ-020 SHALL, when reset_n=0 at a rising clk edge, set pc<=0 and clear all 31 writable registers to 0.
REQ-021 SHALL force memwrite=0 and suppress register writes while reset_n=0, regardless of instr.
REQ-022 SHALL fetch instr at pc=0 in the first cycle after reset_n returns high; reset asserted mid-program aborts the current instruction with no commit.

Structure
REQ-023 SHALL place the following in a shared package, singleriscv_pkg:
- opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
- funct3 constants
- an ALU-operation enumeration
REQ-024 SHALL use one sub-module, singleriscv_regfile, holding the register file, its synchronous reset and x0 handling; decode, ALU and PC logic stay in singleriscv.

Verification
REQ-025 SHALL cover reset: reset_n=0 for 2 edges with instr=SW -> pc=0 and memwrite=0 throughout; after release, pc steps 0,4,8.
REQ-026 SHALL cover ALU and store: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sw x3,8(x0) -> memwrite=1, dataadr=0x8, writedata=0x2.
REQ-027 SHALL cover the completion-signal store: lui x5,0x8; addi x5,x5,-4; addi x6,x0,1; sw x6,0(x5) -> memwrite=1, dataadr=0x00007ffc, writedata=0x1.
REQ-028 SHALL cover branches: with x1=-1, x2=1, blt x1,x2,+8 -> pc advances by 8; bltu x1,x2,+8 -> pc+4; beq x0,x0,-4 -> pc-4.
REQ-029 SHALL cover jumps: jal x1,+16 at pc=0x10 -> x1=0x14 and pc=0x20; jalr x0,1(x1) -> pc=0x14.
REQ-030 SHALL cover load and x0 handling: lw x7,0(x0) with readdata=0xDEADBEEF, then sw x7,4(x0) -> writedata=0xDEADBEEF; addi x0,x0,7 then sw x0,0(x0) -> writedata=0.
